// File: rtl/ex_cluster_pkg.sv
// Shared definitions for the execute cluster: the "value present" tag,
// operand indices and an index-width helper. No configuration macros.
package ex_cluster_pkg;

    // A tag of zero marks an operand whose value is already held.
    localparam int TAG_INVALID = 0;

    typedef enum logic {
        OPND_A = 1'b0,
        OPND_B = 1'b1
    } opnd_e;

    // Index width that stays at least one bit for single-entry sets.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ex_cluster_if.sv
// Issue, dispatch, result and CDB bundle of the execute cluster.
// master: issuing/functional-unit side; slave: the cluster.
interface ex_cluster_if
    import ex_cluster_pkg::*;
#(
    parameter int UNIT_NUM = 2,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int OP_W     = 4
);
    localparam int UW = idx_w(UNIT_NUM);

    logic                       issue_valid;
    logic                       issue_ready;
    logic [UW-1:0]              issue_unit;
    logic [OP_W-1:0]            issue_op;
    logic [TAG_W-1:0]           issue_target;
    logic [2*DATA_W-1:0]        issue_val;
    logic [2*TAG_W-1:0]         issue_tag;

    logic [UNIT_NUM-1:0]        full;

    logic [UNIT_NUM-1:0]        fu_valid;
    logic [UNIT_NUM-1:0]        fu_ready;
    logic [UNIT_NUM*OP_W-1:0]   fu_op;
    logic [UNIT_NUM*DATA_W-1:0] fu_a;
    logic [UNIT_NUM*DATA_W-1:0] fu_b;
    logic [UNIT_NUM*TAG_W-1:0]  fu_target;

    logic [UNIT_NUM-1:0]        res_valid;
    logic [UNIT_NUM-1:0]        res_ready;
    logic [UNIT_NUM*TAG_W-1:0]  res_tag;
    logic [UNIT_NUM*DATA_W-1:0] res_val;

    logic                       cdb_valid;
    logic [TAG_W-1:0]           cdb_tag;
    logic [DATA_W-1:0]          cdb_val;

    modport master (
        output issue_valid, issue_unit, issue_op,
        output issue_target, issue_val, issue_tag,
        input  issue_ready, full,
        input  fu_valid, fu_op, fu_a, fu_b, fu_target,
        output fu_ready,
        output res_valid, res_tag, res_val,
        input  res_ready,
        input  cdb_valid, cdb_tag, cdb_val
    );

    modport slave (
        input  issue_valid, issue_unit, issue_op,
        input  issue_target, issue_val, issue_tag,
        output issue_ready, full,
        output fu_valid, fu_op, fu_a, fu_b, fu_target,
        input  fu_ready,
        input  res_valid, res_tag, res_val,
        output res_ready,
        output cdb_valid, cdb_tag, cdb_val
    );

endinterface

// File: rtl/ex_rs.sv
// One reservation station: age-ordered compacting queue with CDB wakeup
// and oldest-ready select. Ports: push_* in, cdb_* in, full/fu_* out.
module ex_rs
    import ex_cluster_pkg::*;
#(
    parameter int RS_DEPTH = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int OP_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic [OP_W-1:0]     push_op,
    input  logic [TAG_W-1:0]    push_target,
    input  logic [2*DATA_W-1:0] push_val,
    input  logic [2*TAG_W-1:0]  push_tag,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic [DATA_W-1:0]   cdb_val,
    output logic                full,
    output logic                fu_valid,
    input  logic                fu_ready,
    output logic [OP_W-1:0]     fu_op,
    output logic [DATA_W-1:0]   fu_a,
    output logic [DATA_W-1:0]   fu_b,
    output logic [TAG_W-1:0]    fu_target
);

    localparam int IW = idx_w(RS_DEPTH);
    localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_INVALID);

    typedef struct packed {
        logic                   valid;
        logic [OP_W-1:0]        op;
        logic [TAG_W-1:0]       target;
        logic [1:0][DATA_W-1:0] val;
        logic [1:0][TAG_W-1:0]  tag;
    } rs_entry_t;

    rs_entry_t       q    [RS_DEPTH];
    rs_entry_t       woke [RS_DEPTH];
    rs_entry_t       nq   [RS_DEPTH];
    rs_entry_t       in_e;
    rs_entry_t       sel_e;
    logic            sel_hit;
    logic [IW-1:0]   sel_idx;
    logic            pop;
    int              cnt;
    int              tail;

    function automatic rs_entry_t wake(input rs_entry_t e);
        rs_entry_t r;
        r = e;
        for (int k = 0; k < 2; k++) begin
            if (r.valid && cdb_valid &&
                r.tag[k] != TAG_NONE && r.tag[k] == cdb_tag) begin
                r.val[k] = cdb_val;
                r.tag[k] = TAG_NONE;
            end
        end
        return r;
    endfunction

    // Incoming operands see the same broadcast as parked ones.
    always_comb begin
        in_e        = '0;
        in_e.valid  = 1'b1;
        in_e.op     = push_op;
        in_e.target = push_target;
        in_e.val    = push_val;
        in_e.tag    = push_tag;
        in_e        = wake(in_e);
    end

    // Lowest index is oldest, so scan downwards and keep the last hit.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        sel_e   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid &&
                q[i].tag[OPND_A] == TAG_NONE &&
                q[i].tag[OPND_B] == TAG_NONE) begin
                sel_hit = 1'b1;
                sel_idx = IW'(i);
                sel_e   = q[i];
            end
        end
    end

    assign pop = sel_hit && fu_ready && !flush;

    always_comb begin
        cnt = 0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            woke[i] = wake(q[i]);
            cnt = cnt + (q[i].valid ? 1 : 0);
        end
        tail = cnt - (pop ? 1 : 0);
        for (int i = 0; i < RS_DEPTH; i++) begin
            nq[i] = woke[i];
        end
        if (pop) begin
            for (int i = 0; i < RS_DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    nq[i] = woke[i + 1];
                end
            end
            nq[RS_DEPTH - 1] = '0;
        end
        // Push is only granted when not full, so tail is in range.
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (push && i == tail) begin
                nq[i] = in_e;
            end
        end
        if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                nq[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                q[i] <= nq[i];
            end
        end
    end

    assign full      = q[RS_DEPTH - 1].valid;
    assign fu_valid  = sel_hit && !flush;
    assign fu_op     = sel_e.op;
    assign fu_a      = sel_e.val[OPND_A];
    assign fu_b      = sel_e.val[OPND_B];
    assign fu_target = sel_e.target;

endmodule

// File: rtl/ex_cluster.sv
// Execute cluster top: issue steering, per-unit RS, round-robin result
// arbiter and registered CDB. Ports: clk, rst (async, active-low), bus
// (ex_cluster_if.slave), flush when EX_CLUSTER_FLUSH_EN is defined.
module ex_cluster
    import ex_cluster_pkg::*;
#(
    parameter int UNIT_NUM = 2,
    parameter int RS_DEPTH = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int OP_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
`ifdef EX_CLUSTER_FLUSH_EN
    input  logic          flush,
`endif
    ex_cluster_if.slave   bus
);

    localparam int UW = idx_w(UNIT_NUM);

    logic                             flush_i;
    logic                             issue_ok;
    logic [UNIT_NUM-1:0]              push;
    logic [UNIT_NUM-1:0]              full;
    logic [UNIT_NUM-1:0]              fu_valid;
    logic [UNIT_NUM-1:0][OP_W-1:0]    fu_op;
    logic [UNIT_NUM-1:0][DATA_W-1:0]  fu_a;
    logic [UNIT_NUM-1:0][DATA_W-1:0]  fu_b;
    logic [UNIT_NUM-1:0][TAG_W-1:0]   fu_target;

    logic [UW-1:0]                    ptr;
    logic [UW-1:0]                    win;
    logic [UW-1:0]                    ptr_nxt;
    logic                             gnt_any;
    logic [UNIT_NUM-1:0]              grant;
    logic [TAG_W-1:0]                 win_tag;
    logic [DATA_W-1:0]                win_val;

    logic                             cdb_valid;
    logic [TAG_W-1:0]                 cdb_tag;
    logic [DATA_W-1:0]                cdb_val;

`ifdef EX_CLUSTER_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // An out-of-range unit index matches no RS and is never ready.
    always_comb begin
        issue_ok = 1'b0;
        push     = '0;
        for (int u = 0; u < UNIT_NUM; u++) begin
            if (int'(bus.issue_unit) == u) begin
                issue_ok = !full[u];
            end
        end
        if (flush_i) begin
            issue_ok = 1'b0;
        end
        for (int u = 0; u < UNIT_NUM; u++) begin
            if (int'(bus.issue_unit) == u) begin
                push[u] = bus.issue_valid && issue_ok;
            end
        end
    end

    for (genvar u = 0; u < UNIT_NUM; u++) begin : g_rs
        ex_rs #(
            .RS_DEPTH (RS_DEPTH),
            .DATA_W   (DATA_W),
            .TAG_W    (TAG_W),
            .OP_W     (OP_W)
        ) u_rs (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush_i),
            .push        (push[u]),
            .push_op     (bus.issue_op),
            .push_target (bus.issue_target),
            .push_val    (bus.issue_val),
            .push_tag    (bus.issue_tag),
            .cdb_valid   (cdb_valid),
            .cdb_tag     (cdb_tag),
            .cdb_val     (cdb_val),
            .full        (full[u]),
            .fu_valid    (fu_valid[u]),
            .fu_ready    (bus.fu_ready[u]),
            .fu_op       (fu_op[u]),
            .fu_a        (fu_a[u]),
            .fu_b        (fu_b[u]),
            .fu_target   (fu_target[u])
        );

        a_res_tag : assert property (
            @(posedge clk) disable iff (!rst)
            bus.res_valid[u] |->
                bus.res_tag[u*TAG_W +: TAG_W] != TAG_W'(TAG_INVALID)
        );
    end

    // Round-robin: first requester at or after ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        win     = '0;
        grant   = '0;
        for (int k = 0; k < UNIT_NUM; k++) begin
            idx = (int'(ptr) + k) % UNIT_NUM;
            if (!gnt_any && bus.res_valid[idx]) begin
                gnt_any = 1'b1;
                win     = UW'(idx);
            end
        end
        if (flush_i) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            grant[win] = 1'b1;
        end
        win_tag = bus.res_tag[int'(win)*TAG_W +: TAG_W];
        win_val = bus.res_val[int'(win)*DATA_W +: DATA_W];
        ptr_nxt = UW'((int'(win) + 1) % UNIT_NUM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= TAG_W'(TAG_INVALID);
            cdb_val   <= '0;
            ptr       <= '0;
        end else if (gnt_any) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= win_tag;
            cdb_val   <= win_val;
            ptr       <= ptr_nxt;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    assign bus.issue_ready = issue_ok;
    assign bus.full        = full;
    assign bus.fu_valid    = fu_valid;
    assign bus.fu_op       = fu_op;
    assign bus.fu_a        = fu_a;
    assign bus.fu_b        = fu_b;
    assign bus.fu_target   = fu_target;
    assign bus.res_ready   = grant;
    assign bus.cdb_valid   = cdb_valid;
    assign bus.cdb_tag     = cdb_tag;
    assign bus.cdb_val     = cdb_val;

endmodule

// File: tb/tb_ex_cluster.sv
// Directed bench for ex_cluster (UNIT_NUM=2, RS_DEPTH=4).
// Connects flush when EX_CLUSTER_FLUSH_EN is defined (held low).
module tb_ex_cluster;
    import ex_cluster_pkg::*;

    localparam int UN = 2;
    localparam int RD = 4;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_cluster_if #(.UNIT_NUM(UN), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) bus ();

`ifdef EX_CLUSTER_FLUSH_EN
    logic flush = 1'b0;
`endif

    ex_cluster #(
        .UNIT_NUM (UN),
        .RS_DEPTH (RD),
        .DATA_W   (DW),
        .TAG_W    (TW),
        .OP_W     (OW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef EX_CLUSTER_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input int unit, input int op, input int target,
                             input int t2, input int t1,
                             input int v2, input int v1);
        bus.issue_valid  = 1'b1;
        bus.issue_unit   = 1'(unit);
        bus.issue_op     = OW'(op);
        bus.issue_target = TW'(target);
        bus.issue_tag    = {TW'(t2), TW'(t1)};
        bus.issue_val    = {DW'(v2), DW'(v1)};
    endtask

    function automatic logic [63:0] fa(input int u);
        return 64'(bus.fu_a[u*DW +: DW]);
    endfunction
    function automatic logic [63:0] fb(input int u);
        return 64'(bus.fu_b[u*DW +: DW]);
    endfunction
    function automatic logic [63:0] fop(input int u);
        return 64'(bus.fu_op[u*OW +: OW]);
    endfunction
    function automatic logic [63:0] ftg(input int u);
        return 64'(bus.fu_target[u*TW +: TW]);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.issue_valid  = 1'b0;
        bus.issue_unit   = '0;
        bus.issue_op     = '0;
        bus.issue_target = '0;
        bus.issue_tag    = '0;
        bus.issue_val    = '0;
        bus.fu_ready     = '0;
        bus.res_valid    = '0;
        bus.res_tag      = '0;
        bus.res_val      = '0;

        #2;
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_fu_valid", 64'(bus.fu_valid), 64'd0);
        chk("rst_full", 64'(bus.full), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 1: ready operands dispatch the cycle after issue
        set_issue(0, 1, 3, 0, 0, 5, 3);
        bus.fu_ready = 2'b11;
        #1;
        chk("t1_issue_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        bus.issue_valid = 1'b0;
        #1;
        chk("t1_fu_valid", 64'(bus.fu_valid), 64'b01);
        chk("t1_fu_a", fa(0), 64'd3);
        chk("t1_fu_b", fb(0), 64'd5);
        chk("t1_fu_op", fop(0), 64'd1);
        chk("t1_fu_target", ftg(0), 64'd3);
        tick();
        chk("t1_popped", 64'(bus.fu_valid), 64'b00);

        // 2: blocked operand woken by CDB, dispatch one cycle later
        set_issue(0, 2, 4, 0, 7, 16, 0);
        tick();
        bus.issue_valid = 1'b0;
        bus.res_valid   = 2'b10;
        bus.res_tag     = {TW'(7), TW'(0)};
        bus.res_val     = {DW'(32'h2A), DW'(0)};
        #1;
        chk("t2_blocked", 64'(bus.fu_valid), 64'b00);
        chk("t2_res_ready", 64'(bus.res_ready), 64'b10);
        tick();
        bus.res_valid = 2'b00;
        #1;
        chk("t2_cdb_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t2_cdb_tag", 64'(bus.cdb_tag), 64'd7);
        chk("t2_cdb_val", 64'(bus.cdb_val), 64'h2A);
        chk("t2_not_yet", 64'(bus.fu_valid), 64'b00);
        tick();
        chk("t2_cdb_drop", 64'(bus.cdb_valid), 64'd0);
        chk("t2_fu_valid", 64'(bus.fu_valid), 64'b01);
        chk("t2_fu_a", fa(0), 64'h2A);
        chk("t2_fu_b", fb(0), 64'd16);
        tick();
        chk("t2_popped", 64'(bus.fu_valid), 64'b00);

        // 3: fill unit0 with blocked entries
        bus.fu_ready = 2'b00;
        for (int i = 0; i < RD; i++) begin
            set_issue(0, 3, 10 + i, 0, 20, 0, i);
            #1;
            chk("t3_fill_ready", 64'(bus.issue_ready), 64'd1);
            tick();
        end
        #1;
        chk("t3_full", 64'(bus.full), 64'b01);
        chk("t3_ready_u0", 64'(bus.issue_ready), 64'd0);
        tick();
        set_issue(1, 4, 15, 0, 0, 2, 1);
        #1;
        chk("t3_ready_u1", 64'(bus.issue_ready), 64'd1);
        tick();
        bus.issue_valid = 1'b0;
        #1;
        chk("t3_full_after", 64'(bus.full), 64'b01);
        chk("t3_fu_valid", 64'(bus.fu_valid), 64'b10);
        chk("t3_fu_a1", fa(1), 64'd1);

        // 4: both units request, grants alternate
        bus.res_valid = 2'b11;
        bus.res_tag   = {TW'(22), TW'(21)};
        bus.res_val   = {DW'(32'hB2), DW'(32'hB1)};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_grant", 64'(bus.res_ready),
                (k % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            chk("t4_cdb_valid", 64'(bus.cdb_valid), 64'd1);
            chk("t4_cdb_tag", 64'(bus.cdb_tag),
                (k % 2 == 0) ? 64'd21 : 64'd22);
        end
        bus.res_valid = 2'b00;
        tick();
        chk("t4_cdb_idle", 64'(bus.cdb_valid), 64'd0);

        // 5: operand tag matches the broadcast in its issue cycle
        bus.res_valid = 2'b01;
        bus.res_tag   = {TW'(0), TW'(9)};
        bus.res_val   = {DW'(0), DW'(32'h11)};
        #1;
        chk("t5_grant", 64'(bus.res_ready), 64'b01);
        tick();
        bus.res_valid = 2'b00;
        set_issue(1, 5, 6, 0, 9, 32'h33, 0);
        #1;
        chk("t5_cdb_tag", 64'(bus.cdb_tag), 64'd9);
        chk("t5_issue_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        bus.issue_valid = 1'b0;
        bus.fu_ready    = 2'b10;
        #1;
        chk("t5_oldest_op", fop(1), 64'd4);
        tick();
        chk("t5_cdb_gone", 64'(bus.cdb_valid), 64'd0);
        chk("t5_fu_valid", 64'(bus.fu_valid), 64'b10);
        chk("t5_fu_a", fa(1), 64'h11);
        chk("t5_fu_b", fb(1), 64'h33);
        chk("t5_fu_op", fop(1), 64'd5);
        chk("t5_fu_target", ftg(1), 64'd6);

        // 6: asynchronous reset with live entries
        bus.issue_unit = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("t6_fu_valid", 64'(bus.fu_valid), 64'b00);
        chk("t6_full", 64'(bus.full), 64'b00);
        chk("t6_issue_ready", 64'(bus.issue_ready), 64'd1);
        chk("t6_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("t6_cdb_tag", 64'(bus.cdb_tag), 64'd0);
        chk("t6_cdb_val", 64'(bus.cdb_val), 64'd0);
        chk("t6_res_ready", 64'(bus.res_ready), 64'b00);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_after_fu_valid", 64'(bus.fu_valid), 64'b00);
        chk("t6_after_full", 64'(bus.full), 64'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
